instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage upstream of InstructionMemory (synchronous ROM, 1-cycle read latency).
//   - Owns the PC and drives the ROM address.
//   - Tags each returned word with its PC; handles stall, branch/jump redirect and halt.
//   - Presents a valid/stall-qualified instruction stream to the decoder.
// PARAMETERS
//   ADDR_W    32            PC / instruction address width
//   INSTR_W   32            instruction width
//   RESET_PC  32'h0000_0000 first fetch address after reset
//   CNT_W     16            width of accepted-instruction counter
// PORTS
//   clk              in   1        clock; all state updates on posedge
//   rst_n            in   1        asynchronous, active-low reset
//   stall            in   1        downstream not ready; hold current instruction
//   redirect_valid   in   1        branch/jump taken by the currently presented instr
//   redirect_target  in   ADDR_W   new PC; must be word aligned
//   halt             in   1        currently presented instr is a halt
//   instr_add        out  ADDR_W   address to InstructionMemory
//   mem_instr        in   INSTR_W  ROM data; word for the address latched at the last edge
//   instr            out  INSTR_W  instruction to decoder (= mem_instr)
//   instr_pc         out  ADDR_W   PC of instr
//   pc_plus4         out  ADDR_W   instr_pc + 4 (link value)
//   instr_valid      out  1        instr/instr_pc meaningful this cycle
//   fetch_err        out  1        sticky: a misaligned redirect was seen
//   fetch_count      out  CNT_W    number of accepted instructions, wraps
// BEHAVIOUR
//   Registers
//   - fetch_pc: next address to send.
//   - inflight_pc: address whose data is on mem_instr.
//   - state, fetch_err, fetch_count.
//   Reset (async, immediate)
//   - fetch_pc = inflight_pc = RESET_PC, state = S_BOOT.
//   - instr_valid = 0, fetch_err = 0, fetch_count = 0, instr_add = RESET_PC.
//   FSM states: S_BOOT, S_RUN, S_FLUSH, S_HALT.
//   S_BOOT
//   - instr_valid = 0, instr_add = fetch_pc.
//   - At edge: inflight_pc <= fetch_pc, fetch_pc += 4, -> S_RUN.
//   S_RUN
//   - instr_valid = 1, instr_pc = inflight_pc.
//   - "accept" = instr_valid & ~stall; per-cycle priority is halt > redirect > stall > accept.
//   - halt: takes effect only on accept (halt ignored while stall=1). Count +1, -> S_HALT.
//   - redirect_valid: acts even if stall=1. fetch_pc <= {target[ADDR_W-1:2], 2'b00},
//     count +1, -> S_FLUSH. The sequential word fetched at this edge is squashed.
//     If target[1:0] != 0, set fetch_err.
//   - stall (no redirect): instr_add = inflight_pc (combinational mux), so the ROM
//     re-reads the same word; all registers hold; instr and instr_pc stay stable.
//   - accept: inflight_pc <= fetch_pc, fetch_pc += 4, count +1.
//   - Otherwise instr_add = fetch_pc.
//   S_FLUSH
//   - instr_valid = 0; stall, redirect and halt ignored; instr_add = fetch_pc.
//   - At edge: inflight_pc <= fetch_pc, fetch_pc += 4, -> S_RUN.
//   - Taken redirect costs exactly 1 bubble.
//   S_HALT
//   - instr_valid = 0, all registers frozen, instr_add = inflight_pc.
//   - Only rst_n exits.
//   Arithmetic
//   - PC adds are modulo 2^ADDR_W (0xFFFF_FFFC + 4 = 0).
//   - fetch_count wraps modulo 2^CNT_W.
//   Outputs
//   - pc_plus4 = instr_pc + 4, combinational.
//   - instr_valid is a decode of state only.
// STRUCTURE
//   - fetch_pkg holds: state encoding (2-bit localparams), PC_STEP = 4, default RESET_PC.
//   - Single module, no sub-modules. The parent instantiates InstructionMemory and
//     wires instr_add / mem_instr.
// TESTING  (ROM: 0x00=A, 0x04=B, 0x08=C, 0x0C=D, 0x20=E, 0x24=F; clk period 20ns)
//   1. rst_n low 2 cycles, then release.
//      -> cycle 1: instr_valid=0, instr_add=0.
//      -> cycles 2, 3, 4: instr_pc = 0/4/8, instr = A/B/C, fetch_count = 3 after cycle 4.
//   2. stall=1 for 3 cycles while instr_pc=4.
//      -> instr=B, instr_pc=4, instr_add=4, instr_valid=1 throughout.
//      -> after release, next instr_pc=8; no skip, no duplicate.
//   3. redirect_valid=1, target=0x20 at instr_pc=4.
//      -> next cycle instr_valid=0.
//      -> then instr_pc=0x20 (E), then 0x24 (F); pc_plus4=0x24 when on E.
//   4. redirect + stall together, target=0x22.
//      -> redirect wins; fetch resumes at 0x20; fetch_err=1 and stays 1.
//   5. halt at instr_pc=8.
//      -> instr_valid=0 forever, instr_add constant.
//      -> rst_n dropped mid-halt, no clock edge: outputs at reset values immediately;
//         after release, fetch restarts at 0.
//   6. RESET_PC=32'hFFFF_FFFC.
//      -> instr_pc sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.

Source files
------------

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch stage.
//   - fetch_state_e : 2-bit state encoding of the fetch FSM
//   - PC_STEP       : byte distance between sequential instruction words
//   - DEFAULT_RESET_PC : first fetch address after reset unless overridden
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned PC_STEP = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage sitting in front of a synchronous instruction ROM with one
//   cycle of read latency. It owns the PC, drives the ROM address, tags each
//   returned word with the PC it was fetched from and hands a valid-qualified
//   stream to the decoder, honouring stall, branch/jump redirect and halt.
//
// Ports
//   clk             : clock, all state changes on the rising edge
//   rst_n           : asynchronous active-low reset
//   stall           : decoder not ready, keep presenting the current word
//   redirect_valid  : presented instruction is a taken branch/jump
//   redirect_target : new PC for a redirect (expected word aligned)
//   halt            : presented instruction is a halt
//   instr_add       : address to the instruction ROM
//   mem_instr       : ROM data for the address latched at the previous edge
//   instr           : instruction to the decoder
//   instr_pc        : PC of instr
//   pc_plus4        : instr_pc + 4, used as link value
//   instr_valid     : instr / instr_pc are meaningful this cycle
//   fetch_err       : sticky flag, a misaligned redirect target was seen
//   fetch_count     : wrapping count of accepted instructions
// ----------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  instr_add,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               instr_valid,
  output logic               fetch_err,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  // State register. fetch_pc is the next address to send to the ROM and
  // inflight_pc is the address whose data is currently on mem_instr, so the
  // pair always tracks the one-cycle ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      fetch_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_err_q   <= fetch_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and ROM address selection. In RUN the priority is
  // halt > redirect > stall > accept. A halt only takes effect when the
  // instruction is actually accepted, while a redirect acts even under stall.
  // During a plain stall the ROM is pointed back at inflight_pc so the same
  // word is re-read and instr stays stable. A redirect squashes the word
  // fetched at that edge, which is the single FLUSH bubble.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    fetch_err_d   = fetch_err_q;
    fetch_count_d = fetch_count_q;
    instr_add     = fetch_pc_q;

    case (state_q)
      S_BOOT, S_FLUSH: begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + STEP;
        state_d       = S_RUN;
      end
      S_RUN: begin
        if (halt && !stall) begin
          fetch_count_d = fetch_count_q + CNT_W'(1);
          state_d       = S_HALT;
        end else if (redirect_valid) begin
          fetch_pc_d    = {redirect_target[ADDR_W-1:2], 2'b00};
          fetch_count_d = fetch_count_q + CNT_W'(1);
          fetch_err_d   = fetch_err_q | (redirect_target[1:0] != 2'b00);
          state_d       = S_FLUSH;
        end else if (stall) begin
          instr_add = inflight_pc_q;
        end else begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + STEP;
          fetch_count_d = fetch_count_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        instr_add = inflight_pc_q;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign instr_valid = (state_q == S_RUN);
  assign instr       = mem_instr;
  assign instr_pc    = inflight_pc_q;
  assign pc_plus4    = inflight_pc_q + STEP;
  assign fetch_err   = fetch_err_q;
  assign fetch_count = fetch_count_q;

endmodule
